// File: rtl/stack_sequencer_if.sv
// Instruction handshake and stack/ALU control bundle for stack_sequencer.
// The slave modport is the sequencer side; the master modport is the
// fetch/datapath side that drives instructions and observes the strobes.
// STK_INSTR_COUNT_EN adds the instr_count signal to both modports.
interface stack_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int SP_W  = 4
);
  logic            instr_valid;
  logic            instr_ready;
  logic [2:0]      opcode;
  logic [2:0]      funct;
  logic            alu_zero;
  logic [SP_W-1:0] stk_addr;
  logic            stk_re;
  logic            stk_we;
  logic            opa_le;
  logic            opb_le;
  logic [2:0]      alu_ctrl;
  logic            mem_re;
  logic            mem_we;
  logic            pc_load;
  logic [SP_W:0]   sp;
  logic            busy;
  logic            err;
`ifdef STK_INSTR_COUNT_EN
  logic [15:0]     instr_count;

  modport slave (
    input  instr_valid, opcode, funct, alu_zero,
    output instr_ready, stk_addr, stk_re, stk_we, opa_le, opb_le,
    output alu_ctrl, mem_re, mem_we, pc_load, sp, busy, err, instr_count
  );

  modport master (
    output instr_valid, opcode, funct, alu_zero,
    input  instr_ready, stk_addr, stk_re, stk_we, opa_le, opb_le,
    input  alu_ctrl, mem_re, mem_we, pc_load, sp, busy, err, instr_count
  );
`else
  modport slave (
    input  instr_valid, opcode, funct, alu_zero,
    output instr_ready, stk_addr, stk_re, stk_we, opa_le, opb_le,
    output alu_ctrl, mem_re, mem_we, pc_load, sp, busy, err
  );

  modport master (
    output instr_valid, opcode, funct, alu_zero,
    input  instr_ready, stk_addr, stk_re, stk_we, opa_le, opb_le,
    input  alu_ctrl, mem_re, mem_we, pc_load, sp, busy, err
  );
`endif
endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle sequencer for the stack-machine datapath.
// Accepts one decoded instruction, pops 0..2 operands from the stack RF,
// runs a single EXEC cycle (ALU / memory / branch), then optionally pushes
// the result. Owns the stack pointer and traps underflow/overflow into a
// sticky ERR state that only reset leaves.
// Optional feature macro: STK_INSTR_COUNT_EN (adds a 16-bit EXEC counter).
module stack_sequencer #(
  parameter int DEPTH = 16,
  parameter int SP_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  stack_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POPA = 3'd1,
    S_POPB = 3'd2,
    S_EXEC = 3'd3,
    S_PUSH = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Instruction groups
  localparam logic [2:0] OP_ARITH   = 3'b000;
  localparam logic [2:0] OP_IMM     = 3'b100;
  localparam logic [2:0] OP_LOAD    = 3'b010;
  localparam logic [2:0] OP_STORE   = 3'b110;
  localparam logic [2:0] OP_COMPARE = 3'b001;
  localparam logic [2:0] OP_BRANCH  = 3'b011;
  localparam logic [2:0] OP_PUSH_PC = 3'b101;
  localparam logic [2:0] OP_POP_PC  = 3'b111;

  // Fault arithmetic is done two bits wider than SP_W so that sp-p+q
  // can exceed DEPTH without wrapping.
  localparam int              XW      = SP_W + 2;
  localparam logic [XW-1:0]   DEPTH_X = XW'(DEPTH);

  // Number of operands each group pops.
  function automatic logic [1:0] pops_of(input logic [2:0] op);
    logic [1:0] n;
    case (op)
      OP_ARITH, OP_STORE, OP_COMPARE:        n = 2'd2;
      OP_IMM, OP_LOAD, OP_BRANCH, OP_POP_PC: n = 2'd1;
      default:                               n = 2'd0;  // push_pc
    endcase
    return n;
  endfunction

  // Whether each group pushes a result.
  function automatic logic pushes_of(input logic [2:0] op);
    logic n;
    case (op)
      OP_ARITH, OP_IMM, OP_LOAD, OP_COMPARE, OP_PUSH_PC: n = 1'b1;
      default:                                           n = 1'b0;
    endcase
    return n;
  endfunction

  state_t        state_q, state_d;
  logic [SP_W:0] sp_q, sp_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    funct_q, funct_d;

  // Fault detection on the incoming (not yet captured) instruction
  logic [1:0]    in_pops;
  logic          in_push;
  logic [XW-1:0] sp_x;
  logic [XW-1:0] sp_after;
  logic          underflow;
  logic          overflow;
  logic          accept;

  // Pop/push counts of the instruction currently being executed
  logic [1:0]    cur_pops;
  logic          cur_push;

  // Stack address one below the top of stack (used by both pop cycles)
  logic [SP_W:0] sp_m1;

  // Moore output shadows driven onto the interface
  logic            instr_ready_o;
  logic [SP_W-1:0] stk_addr_o;
  logic            stk_re_o;
  logic            stk_we_o;
  logic            opa_le_o;
  logic            opb_le_o;
  logic [2:0]      alu_ctrl_o;
  logic            mem_re_o;
  logic            mem_we_o;
  logic            pc_load_o;
  logic            busy_o;
  logic            err_o;

  assign in_pops   = pops_of(bus.opcode);
  assign in_push   = pushes_of(bus.opcode);
  assign sp_x      = {1'b0, sp_q};
  assign sp_after  = sp_x - XW'(in_pops) + XW'(in_push);
  assign underflow = (sp_x < XW'(in_pops));
  assign overflow  = (sp_after > DEPTH_X);
  assign accept    = (state_q == S_IDLE) && bus.instr_valid;

  assign cur_pops  = pops_of(op_q);
  assign cur_push  = pushes_of(op_q);
  assign sp_m1     = sp_q - 1'b1;

  // State, stack pointer and captured instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  // Next-state sequencing; sp moves by one on each pop and push cycle
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    op_d    = op_q;
    funct_d = funct_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (underflow || overflow) begin
            // sp is left untouched on a fault
            state_d = S_ERR;
          end else begin
            op_d    = bus.opcode;
            funct_d = bus.funct;
            state_d = (in_pops != 2'd0) ? S_POPA : S_EXEC;
          end
        end
      end
      S_POPA: begin
        sp_d    = sp_m1;
        state_d = (cur_pops == 2'd2) ? S_POPB : S_EXEC;
      end
      S_POPB: begin
        sp_d    = sp_m1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = cur_push ? S_PUSH : S_IDLE;
      end
      S_PUSH: begin
        sp_d    = sp_q + 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the registered state; only pc_load for branches
  // additionally looks at the ALU zero flag during EXEC
  always_comb begin
    instr_ready_o = (state_q == S_IDLE);
    busy_o        = (state_q != S_IDLE);
    err_o         = (state_q == S_ERR);
    stk_addr_o    = '0;
    stk_re_o      = 1'b0;
    stk_we_o      = 1'b0;
    opa_le_o      = 1'b0;
    opb_le_o      = 1'b0;
    alu_ctrl_o    = '0;
    mem_re_o      = 1'b0;
    mem_we_o      = 1'b0;
    pc_load_o     = 1'b0;
    case (state_q)
      S_POPA: begin
        stk_re_o   = 1'b1;
        opa_le_o   = 1'b1;
        stk_addr_o = sp_m1[SP_W-1:0];
      end
      S_POPB: begin
        stk_re_o   = 1'b1;
        opb_le_o   = 1'b1;
        stk_addr_o = sp_m1[SP_W-1:0];
      end
      S_EXEC: begin
        alu_ctrl_o = funct_q;
        mem_re_o   = (op_q == OP_LOAD);
        mem_we_o   = (op_q == OP_STORE);
        if (op_q == OP_BRANCH) begin
          // funct[0] selects branch-if-nonzero versus branch-if-zero
          pc_load_o = funct_q[0] ? ~bus.alu_zero : bus.alu_zero;
        end else if (op_q == OP_POP_PC) begin
          pc_load_o = 1'b1;
        end
      end
      S_PUSH: begin
        // A push is only reached when sp < DEPTH, so the low bits suffice
        stk_we_o   = 1'b1;
        stk_addr_o = sp_q[SP_W-1:0];
      end
      default: begin
      end
    endcase
  end

  assign bus.instr_ready = instr_ready_o;
  assign bus.stk_addr    = stk_addr_o;
  assign bus.stk_re      = stk_re_o;
  assign bus.stk_we      = stk_we_o;
  assign bus.opa_le      = opa_le_o;
  assign bus.opb_le      = opb_le_o;
  assign bus.alu_ctrl    = alu_ctrl_o;
  assign bus.mem_re      = mem_re_o;
  assign bus.mem_we      = mem_we_o;
  assign bus.pc_load     = pc_load_o;
  assign bus.sp          = sp_q;
  assign bus.busy        = busy_o;
  assign bus.err         = err_o;

`ifdef STK_INSTR_COUNT_EN
  logic [15:0] instr_count_q;

  // Count executed instructions; faulted ones never reach EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count_q <= '0;
    end else if (state_q == S_EXEC) begin
      instr_count_q <= instr_count_q + 16'd1;
    end
  end

  assign bus.instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: a reference model pushes the expected
// per-cycle strobe pattern of each issued instruction into a queue, and a
// negedge monitor pops and compares one entry per busy cycle.
module tb_stack_sequencer;
  localparam int DEPTH = 16;
  localparam int SP_W  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  stack_sequencer_if #(.DEPTH(DEPTH), .SP_W(SP_W)) bus ();

  stack_sequencer #(.DEPTH(DEPTH), .SP_W(SP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {stk_re, stk_we, opa_le, opb_le, mem_re, mem_we, pc_load, alu_ctrl, stk_addr, sp}
  logic [18:0] sb[$];
  int          model_sp  = 0;
  logic [15:0] model_cnt = '0;
  bit          mon_en    = 1'b0;

  // Pops/pushes per opcode value 0..7 (000 arith .. 111 pop_pc)
  int pops_t   [8] = '{2, 2, 1, 1, 1, 0, 2, 1};
  int pushes_t [8] = '{1, 1, 1, 0, 1, 1, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] rec(input bit re, input bit we, input bit opa, input bit opb,
                                      input bit mre, input bit mwe, input bit pcl,
                                      input logic [2:0] alu, input logic [3:0] addr,
                                      input logic [4:0] spv);
    return {re, we, opa, opb, mre, mwe, pcl, alu, addr, spv};
  endfunction

  function automatic logic [18:0] obs_rec();
    return {bus.stk_re, bus.stk_we, bus.opa_le, bus.opb_le, bus.mem_re, bus.mem_we,
            bus.pc_load, bus.alu_ctrl, bus.stk_addr, bus.sp};
  endfunction

  // Cycle monitor: one scoreboard entry per busy cycle, quiet strobes otherwise
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.err) begin
        check("err_strobes_quiet", obs_rec() >> 5, 32'd0);
      end else if (bus.busy) begin
        check("busy_cycle_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("cycle_outputs", obs_rec(), sb.pop_front());
        end
      end else begin
        check("idle_strobes_quiet", obs_rec() >> 5, 32'd0);
      end
    end
  end

  // Reference model of one legal instruction: expected cycles plus sp/count update
  task automatic expect_instr(input logic [2:0] op, input logic [2:0] fn, input logic zero);
    int   p = pops_t[op];
    int   q = pushes_t[op];
    logic pcl;
    for (int i = 0; i < p; i++) begin
      sb.push_back(rec(1'b1, 1'b0, i == 0, i == 1, 1'b0, 1'b0, 1'b0, 3'd0,
                       4'(model_sp - 1 - i), 5'(model_sp - i)));
    end
    pcl = (op == 3'b011) ? (fn[0] ? ~zero : zero) : (op == 3'b111);
    sb.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, op == 3'b010, op == 3'b110, pcl, fn,
                     4'd0, 5'(model_sp - p)));
    if (q != 0) begin
      sb.push_back(rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0,
                       4'(model_sp - p), 5'(model_sp - p)));
    end
    model_sp  = model_sp - p + q;
    model_cnt = model_cnt + 16'd1;
  endtask

  // Wait (bounded) for return to IDLE; returns cycles counted
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.instr_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issue one instruction from IDLE (called at posedge+1) and check its result
  task automatic issue(input logic [2:0] op, input logic [2:0] fn, input logic zero);
    int  p = pops_t[op];
    int  q = pushes_t[op];
    int  n;
    bit  fault;
    fault = (model_sp < p) || (model_sp - p + q > DEPTH);
    if (!fault) expect_instr(op, fn, zero);
    bus.alu_zero    = zero;
    bus.opcode      = op;
    bus.funct       = fn;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    if (fault) begin
      $display("issue op=%b funct=%b -> fault expected, sp=%0d", op, fn, model_sp);
      check("fault_err", 32'(bus.err), 32'd1);
      check("fault_sp_kept", 32'(bus.sp), 32'(model_sp));
      check("fault_not_ready", 32'(bus.instr_ready), 32'd0);
    end else begin
      wait_ready(n);
      $display("issue op=%b funct=%b zero=%b -> %0d cycles, sp=%0d", op, fn, zero, n, bus.sp);
      check("occupancy", 32'(n), 32'(p + 1 + q));
      check("sp_after", 32'(bus.sp), 32'(model_sp));
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
    end
`ifdef STK_INSTR_COUNT_EN
    check("instr_count", 32'(bus.instr_count), 32'(model_cnt));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset     = 1'b0;
    model_sp  = 0;
    model_cnt = '0;
    sb.delete();
  endtask

  initial begin
    int acc;
    int cyc;
    int n;
    bit r;
    bus.instr_valid = 1'b0;
    bus.opcode      = 3'd0;
    bus.funct       = 3'd0;
    bus.alu_zero    = 1'b0;
    #1;
    do_reset();

    // Reset state
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_sp", 32'(bus.sp), 32'd0);
    check("rst_strobes", obs_rec(), 32'd0);
`ifdef STK_INSTR_COUNT_EN
    check("rst_instr_count", 32'(bus.instr_count), 32'd0);
`endif
    mon_en = 1'b1;

    // Build a stack of 3, then every group once
    issue(3'b101, 3'd0, 1'b0);
    issue(3'b101, 3'd3, 1'b0);
    issue(3'b101, 3'd7, 1'b0);
    issue(3'b000, 3'b010, 1'b0);   // arith at sp=3 -> 2
    issue(3'b010, 3'd3, 1'b0);     // load
    issue(3'b001, 3'd5, 1'b0);     // compare -> sp 1
    issue(3'b100, 3'd1, 1'b0);     // imm
    issue(3'b011, 3'b000, 1'b1);   // branch if zero, zero=1 -> pc_load
    issue(3'b101, 3'd0, 1'b0);
    issue(3'b011, 3'b001, 1'b1);   // branch if nonzero, zero=1 -> no load
    issue(3'b101, 3'd0, 1'b0);
    issue(3'b111, 3'd4, 1'b0);     // pop_pc -> unconditional pc_load
    issue(3'b101, 3'd1, 1'b0);
    issue(3'b101, 3'd2, 1'b0);
    issue(3'b110, 3'd6, 1'b0);     // store -> sp 0

    // instr_valid held high: exactly one accept per IDLE visit
    for (int i = 0; i < 3; i++) expect_instr(3'b101, 3'd6, 1'b0);
    bus.opcode      = 3'b101;
    bus.funct       = 3'd6;
    bus.instr_valid = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 60) begin
      r = bus.instr_ready;
      @(posedge clk); #1;
      cyc++;
      if (r) acc++;
    end
    bus.instr_valid = 1'b0;
    wait_ready(n);
    $display("held-valid burst: %0d accepts in %0d cycles, sp=%0d", acc, cyc, bus.sp);
    check("held_accepts", 32'(acc), 32'd3);
    check("held_sp", 32'(bus.sp), 32'(model_sp));
    check("held_drained", 32'(sb.size()), 32'd0);
`ifdef STK_INSTR_COUNT_EN
    check("held_instr_count", 32'(bus.instr_count), 32'(model_cnt));
`endif

    // Reset in the middle of POPB
    issue(3'b101, 3'd0, 1'b0);     // sp 4
    mon_en          = 1'b0;
    bus.opcode      = 3'b000;
    bus.funct       = 3'b010;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    check("mid_popa_addr", 32'(bus.stk_addr), 32'd3);
    @(posedge clk); #1;
    check("mid_popb_opb", 32'(bus.opb_le), 32'd1);
    #2 reset = 1'b1;
    #1;
    $display("reset asserted in POPB: busy=%b sp=%0d", bus.busy, bus.sp);
    check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
    check("mid_rst_sp", 32'(bus.sp), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    check("mid_rst_strobes", obs_rec(), 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    model_sp  = 0;
    model_cnt = '0;
    sb.delete();
    mon_en    = 1'b1;
`ifdef STK_INSTR_COUNT_EN
    check("mid_rst_instr_count", 32'(bus.instr_count), 32'd0);
`endif

    // Underflow: arith at sp=0, then ERR is sticky
    issue(3'b000, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      check("err_sticky_ready", 32'(bus.instr_ready), 32'd0);
    end
    bus.instr_valid = 1'b0;
    check("err_sticky_err", 32'(bus.err), 32'd1);
    do_reset();
    check("err_cleared", 32'(bus.err), 32'd0);

    // Fill to DEPTH-1, arith is legal there, then fill and overflow
    for (int i = 0; i < DEPTH - 1; i++) issue(3'b101, 3'(i), 1'b0);
    issue(3'b000, 3'b111, 1'b0);   // sp 15 -> 14
    issue(3'b101, 3'd0, 1'b0);     // 15
    issue(3'b101, 3'd0, 1'b0);     // PUSH addr 15, sp 16
    check("full_no_err", 32'(bus.err), 32'd0);
    check("full_sp", 32'(bus.sp), 32'd16);
    issue(3'b101, 3'd0, 1'b0);     // overflow
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
